// File: rtl/databreak_ctl_pkg.sv
// Shared definitions for the multi-channel data-break controller.
// Break state codes live here so CPU-side sequencing can reference them too.
package databreak_ctl_pkg;

    // Field bits that prefix the 12-bit word-count/current-address pointer.
    localparam int FW = 3;

    typedef enum logic [3:0] {
        DB_IDLE   = 4'd0,
        DB_GNT    = 4'd1,
        DB_WC_RD  = 4'd2,
        DB_WC_W1  = 4'd3,
        DB_WC_CAP = 4'd4,
        DB_WC_WR  = 4'd5,
        DB_CA_RD  = 4'd6,
        DB_CA_W1  = 4'd7,
        DB_CA_CAP = 4'd8,
        DB_CA_WR  = 4'd9,
        DB_DT     = 4'd10,
        DB_DT_W1  = 4'd11,
        DB_DT_CAP = 4'd12,
        DB_ACK    = 4'd13
    } db_state_e;

endpackage

// File: rtl/databreak_ctl_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
// Kept generic so interrupt arbitration can reuse it.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           valid,
    output logic [IW-1:0]  idx
);

    // Walk from farthest to nearest so the lane closest to ptr is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NCH]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/databreak_ctl.sv
// Multi-channel data-break controller: arbitrates peripheral channels, requests a
// CPU break, then runs a 1-cycle or PDP-8 3-cycle (WC, CA, data) memory sequence.
module databreak_ctl
    import databreak_ctl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 15,
    parameter int DW  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_dir,
    input  logic [NCH-1:0]    ch_3cyc,
    input  logic [NCH-1:0]    ch_cainc,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_ack,
    output logic [DW-1:0]     ch_rdata,
    output logic              ch_wco,
    output logic              brk_req,
    input  logic              brk_gnt,
    output logic              brk_done,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = AW - FW;

    db_state_e         r_state, w_state_nxt;
    logic [IW-1:0]     r_ptr, r_idx;
    logic              r_dir, r_3cyc, r_cainc;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata, r_wc, r_ca, r_rdata;
    logic              r_wco;
    logic [NCH-1:0]    r_ack, w_ack_nxt;
    logic              r_brk_req, w_brk_req_nxt;
    logic              r_brk_done, w_brk_done_nxt;
    logic [AW-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [DW-1:0]     r_mem_wdata, w_mem_wdata_nxt;

    logic              w_arb_vld;
    logic [IW-1:0]     w_arb_idx;
    logic              w_latch;
    logic [FW-1:0]     w_field;
    logic [PW-1:0]     w_wcp, w_cap;
    logic [AW-1:0]     w_wc_addr, w_ca_addr, w_xfer_addr;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req   (ch_req),
        .ptr   (r_ptr),
        .valid (w_arb_vld),
        .idx   (w_arb_idx)
    );

    assign w_latch     = (r_state == DB_IDLE) && w_arb_vld;
    assign w_field     = r_addr[AW-1 -: FW];
    assign w_wcp       = r_addr[PW-1:0];
    assign w_cap       = w_wcp + PW'(1);
    assign w_wc_addr   = {{FW{1'b0}}, w_wcp};
    assign w_ca_addr   = {{FW{1'b0}}, w_cap};
    // CA already carries the increment, so the transfer uses the updated address.
    assign w_xfer_addr = r_3cyc ? {w_field, PW'(r_ca)} : r_addr;

    always_comb begin
        w_state_nxt     = r_state;
        w_brk_req_nxt   = r_brk_req;
        w_brk_done_nxt  = 1'b0;
        w_ack_nxt       = '0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            DB_IDLE: begin
                if (w_arb_vld) begin
                    w_brk_req_nxt = 1'b1;
                    w_state_nxt   = DB_GNT;
                end
            end
            DB_GNT: begin
                if (brk_gnt) begin
                    w_brk_req_nxt = 1'b0;
                    w_state_nxt   = r_3cyc ? DB_WC_RD : DB_DT;
                end
            end
            DB_WC_RD: begin
                w_mem_addr_nxt = w_wc_addr;
                w_state_nxt    = DB_WC_W1;
            end
            DB_WC_W1:  w_state_nxt = DB_WC_CAP;
            DB_WC_CAP: w_state_nxt = DB_WC_WR;
            DB_WC_WR: begin
                w_mem_addr_nxt  = w_wc_addr;
                w_mem_we_nxt    = 1'b1;
                w_mem_wdata_nxt = r_wc;
                w_state_nxt     = DB_CA_RD;
            end
            DB_CA_RD: begin
                w_mem_addr_nxt = w_ca_addr;
                w_state_nxt    = DB_CA_W1;
            end
            DB_CA_W1:  w_state_nxt = DB_CA_CAP;
            DB_CA_CAP: w_state_nxt = r_cainc ? DB_CA_WR : DB_DT;
            DB_CA_WR: begin
                w_mem_addr_nxt  = w_ca_addr;
                w_mem_we_nxt    = 1'b1;
                w_mem_wdata_nxt = r_ca;
                w_state_nxt     = DB_DT;
            end
            DB_DT: begin
                w_mem_addr_nxt  = w_xfer_addr;
                w_mem_we_nxt    = ~r_dir;
                w_mem_wdata_nxt = r_wdata;
                w_state_nxt     = DB_DT_W1;
            end
            DB_DT_W1:  w_state_nxt = DB_DT_CAP;
            DB_DT_CAP: w_state_nxt = DB_ACK;
            DB_ACK: begin
                w_ack_nxt[r_idx] = 1'b1;
                w_brk_done_nxt   = 1'b1;
                w_state_nxt      = DB_IDLE;
            end
            default:   w_state_nxt = DB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= DB_IDLE;
            r_ptr       <= '0;
            r_brk_req   <= 1'b0;
            r_brk_done  <= 1'b0;
            r_ack       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_wco       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_brk_req   <= w_brk_req_nxt;
            r_brk_done  <= w_brk_done_nxt;
            r_ack       <= w_ack_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (w_latch)
                r_wco <= 1'b0;
            else if (r_state == DB_WC_WR)
                r_wco <= (r_wc == '0);
            if (r_state == DB_DT_CAP && r_dir)
                r_rdata <= mem_rdata;
            if (r_state == DB_ACK)
                r_ptr <= (r_idx == IW'(NCH - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    // Latched request descriptor and WC/CA working values; no reset needed.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_idx   <= w_arb_idx;
            r_dir   <= ch_dir[w_arb_idx];
            r_3cyc  <= ch_3cyc[w_arb_idx];
            r_cainc <= ch_cainc[w_arb_idx];
            r_addr  <= ch_addr[int'(w_arb_idx)*AW +: AW];
            r_wdata <= ch_wdata[int'(w_arb_idx)*DW +: DW];
        end
        if (r_state == DB_WC_CAP)
            r_wc <= mem_rdata + DW'(1);
        if (r_state == DB_CA_CAP)
            r_ca <= mem_rdata + DW'(r_cainc);
    end

    assign ch_ack    = r_ack;
    assign ch_rdata  = r_rdata;
    assign ch_wco    = r_wco;
    assign brk_req   = r_brk_req;
    assign brk_done  = r_brk_done;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_databreak_ctl.sv
// Directed bench for databreak_ctl with a synchronous RAM model and a CPU grant model.
module tb_databreak_ctl;

    localparam int NCH = 4;
    localparam int AW  = 15;
    localparam int DW  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req, ch_dir, ch_3cyc, ch_cainc;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_rdata;
    logic              ch_wco, brk_req, brk_gnt, brk_done;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    always #5 clk = ~clk;

    databreak_ctl #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_req    (ch_req),
        .ch_dir    (ch_dir),
        .ch_3cyc   (ch_3cyc),
        .ch_cainc  (ch_cainc),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_ack    (ch_ack),
        .ch_rdata  (ch_rdata),
        .ch_wco    (ch_wco),
        .brk_req   (brk_req),
        .brk_gnt   (brk_gnt),
        .brk_done  (brk_done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // RAM with one-cycle synchronous read plus a preload port for setup.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            we_cnt  = 0;
    int            ack_cnt = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (|ch_ack)
            ack_cnt <= ack_cnt + 1;
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    logic [NCH-1:0] a_ack;
    logic [DW-1:0]  a_rdata;
    logic           a_wco, a_done;
    int             lat, we0, ack0;

    // Grant the pending break and wait for its ack; lat counts cycles from grant.
    task automatic run_break(input logic drop, output int l);
        int t;
        t = 0;
        while (brk_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("brk_req_rise", brk_req, 1'b1);
        brk_gnt = 1'b1;
        @(negedge clk);
        check("brk_req_drop", brk_req, 1'b0);
        l = 1;
        while (ch_ack == '0 && l < 40) begin
            @(negedge clk);
            l++;
        end
        a_ack   = ch_ack;
        a_rdata = ch_rdata;
        a_wco   = ch_wco;
        a_done  = brk_done;
        brk_gnt = 1'b0;
        if (drop)
            ch_req = ch_req & ~ch_ack;
    endtask

    logic [NCH-1:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        reset = 1'b1; brk_gnt = 1'b0;
        ch_req = '0; ch_dir = '0; ch_3cyc = '0; ch_cainc = '0;
        ch_addr = '0; ch_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_brk_req",   brk_req,   1'b0);
        check("rst_brk_done",  brk_done,  1'b0);
        check("rst_ch_ack",    ch_ack,    '0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_ch_rdata",  ch_rdata,  '0);
        check("rst_ch_wco",    ch_wco,    1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Channel 0, single-cycle write
        ch_addr[0*AW +: AW]  = 15'o12345;
        ch_wdata[0*DW +: DW] = 12'o4321;
        we0 = we_cnt;
        ch_req = 4'b0001;
        run_break(1'b1, lat);
        check("t1_latency", lat, 5);
        check("t1_ack",     a_ack, 4'b0001);
        check("t1_done",    a_done, 1'b1);
        check("t1_we_cnt",  we_cnt - we0, 1);
        check("t1_waddr",   last_wa, 15'o12345);
        check("t1_wdata",   last_wd, 12'o4321);
        check("t1_ram",     ram[15'o12345], 12'o4321);

        // Channel 2, single-cycle read
        preload(15'o00200, 12'o7070);
        ch_dir[2] = 1'b1;
        ch_addr[2*AW +: AW] = 15'o00200;
        we0 = we_cnt;
        ch_req = 4'b0100;
        run_break(1'b1, lat);
        check("t2_latency", lat, 5);
        check("t2_ack",     a_ack, 4'b0100);
        check("t2_rdata",   a_rdata, 12'o7070);
        check("t2_no_we",   we_cnt - we0, 0);

        // Channel 1, three-cycle write with CA increment, two breaks
        preload(15'o00030, 12'o7776);
        preload(15'o00031, 12'o0477);
        ch_3cyc[1] = 1'b1; ch_cainc[1] = 1'b1;
        ch_addr[1*AW +: AW]  = {3'd2, 12'o0030};
        ch_wdata[1*DW +: DW] = 12'o1234;
        ch_req = 4'b0010;
        run_break(1'b1, lat);
        check("t3a_latency", lat, 13);
        check("t3a_ack",     a_ack, 4'b0010);
        check("t3a_wco",     a_wco, 1'b0);
        check("t3a_wc",      ram[15'o00030], 12'o7777);
        check("t3a_ca",      ram[15'o00031], 12'o0500);
        check("t3a_data",    ram[15'o20500], 12'o1234);
        ch_wdata[1*DW +: DW] = 12'o5555;
        ch_req = 4'b0010;
        run_break(1'b1, lat);
        check("t3b_wco",  a_wco, 1'b1);
        check("t3b_wc",   ram[15'o00030], 12'o0000);
        check("t3b_ca",   ram[15'o00031], 12'o0501);
        check("t3b_data", ram[15'o20501], 12'o5555);

        // Round-robin with continuous requests from pointer 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ch_3cyc = '0; ch_cainc = '0; ch_dir = 4'b1111;
        ch_req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            run_break(1'b0, lat);
            check($sformatf("rr%0d_ack", i),  a_ack, rr_exp[i]);
            check($sformatf("rr%0d_done", i), a_done, 1'b1);
        end
        ch_req = '0;
        @(negedge clk);

        // CA wrap 7777 -> 0000 in field 3
        preload(15'o00030, 12'o0100);
        preload(15'o00031, 12'o7777);
        ch_dir = '0; ch_3cyc[1] = 1'b1; ch_cainc[1] = 1'b1;
        ch_addr[1*AW +: AW]  = {3'd3, 12'o0030};
        ch_wdata[1*DW +: DW] = 12'o2222;
        ch_req = 4'b0010;
        run_break(1'b1, lat);
        check("t5_latency", lat, 13);
        check("t5_ca_wrap", ram[15'o00031], 12'o0000);
        check("t5_waddr",   last_wa, 15'o30000);
        check("t5_data",    ram[15'o30000], 12'o2222);

        // Reset during CA_W1, then a clean retry without CA increment
        preload(15'o00030, 12'o0010);
        preload(15'o00031, 12'o0100);
        ch_cainc[1] = 1'b0;
        ch_addr[1*AW +: AW]  = {3'd1, 12'o0030};
        ch_wdata[1*DW +: DW] = 12'o3333;
        ack0 = ack_cnt;
        ch_req = 4'b0010;
        for (int t = 0; t < 20 && brk_req !== 1'b1; t++) @(negedge clk);
        check("t6_brk_req", brk_req, 1'b1);
        brk_gnt = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_brk_req", brk_req, 1'b0);
        check("t6_rst_mem_we",  mem_we, 1'b0);
        check("t6_rst_ack",     ch_ack, '0);
        check("t6_rst_done",    brk_done, 1'b0);
        check("t6_wc_kept",     ram[15'o00030], 12'o0011);
        reset = 1'b0;
        brk_gnt = 1'b0;
        @(negedge clk);
        check("t6_no_ack", ack_cnt - ack0, 0);
        run_break(1'b1, lat);
        check("t6_latency", lat, 12);
        check("t6_ack",     a_ack, 4'b0010);
        check("t6_wc",      ram[15'o00030], 12'o0012);
        check("t6_ca_same", ram[15'o00031], 12'o0100);
        check("t6_data",    ram[15'o10100], 12'o3333);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
